// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : micro_sequencer
//  Purpose  : Generates the 8-bit microaddress for a combinational control
//             store. Each cycle it takes the current microword's sequencing
//             fields (micro_ad, count, bop), the instruction opcode, go_bar
//             and the ALU flags, and registers the next microaddress. A small
//             return-address stack lets opcodes share microcode subroutines.
//
//  Ports    : clk          - system clock, rising-edge active
//             rst          - synchronous active-high reset
//             micro_ad     - branch target {MICRO_AD_HIGH, MICRO_AD_LOW}
//             count        - increment microaddress when no branch is taken
//             bop          - branch operation code
//             opcode       - instruction opcode (used by bop 1111)
//             go_bar       - active-low GO, already synchronised
//             zero/carry/sign - ALU status flags, sampled at the edge
//             microaddress - registered address to the control store
//             op_fetch     - combinational, high when bop == 1111
//             stack_empty  - registered, stack pointer is zero
//             stack_full   - registered, stack pointer equals STACK_DEPTH
//             stack_err    - registered sticky overflow/underflow flag
//
//  Revision : 1.0  initial release
// ============================================================================
module micro_sequencer #(
    parameter int STACK_DEPTH = 4,
    parameter int SP_W        = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] micro_ad,
    input  logic       count,
    input  logic [3:0] bop,
    input  logic [3:0] opcode,
    input  logic       go_bar,
    input  logic       zero,
    input  logic       carry,
    input  logic       sign,
    output logic [7:0] microaddress,
    output logic       op_fetch,
    output logic       stack_empty,
    output logic       stack_full,
    output logic       stack_err
);

    // ------------------------------------------------------------------
    // Branch operation encodings
    // ------------------------------------------------------------------
    localparam logic [3:0] c_BOP_NEVER   = 4'b0000;
    localparam logic [3:0] c_BOP_ZERO    = 4'b0001;
    localparam logic [3:0] c_BOP_CARRY   = 4'b0010;
    localparam logic [3:0] c_BOP_SIGN    = 4'b0011;
    localparam logic [3:0] c_BOP_GO_HIGH = 4'b0100;
    localparam logic [3:0] c_BOP_NZERO   = 4'b0101;
    localparam logic [3:0] c_BOP_NEVER2  = 4'b0110;
    localparam logic [3:0] c_BOP_NCARRY  = 4'b0111;
    localparam logic [3:0] c_BOP_CALL    = 4'b1000;
    localparam logic [3:0] c_BOP_RETURN  = 4'b1001;
    localparam logic [3:0] c_BOP_ALWAYS  = 4'b1110;
    localparam logic [3:0] c_BOP_FETCH   = 4'b1111;

    // The pointer needs one extra bit so that "full" (sp == STACK_DEPTH)
    // is distinguishable from "empty" (sp == 0).
    localparam logic [SP_W:0]   c_SP_FULL  = (SP_W+1)'(STACK_DEPTH);
    localparam logic [SP_W:0]   c_SP_ONE   = (SP_W+1)'(1);
    localparam logic [SP_W-1:0] c_IDX_ONE  = SP_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]    r_ma;
    logic [SP_W:0] r_sp;
    logic          r_empty;
    logic          r_full;
    logic          r_err;
    logic [7:0]    r_stack [STACK_DEPTH];

    // ------------------------------------------------------------------
    // Combinational next-state
    // ------------------------------------------------------------------
    logic [7:0]      w_inc;
    logic            w_sp_is_full;
    logic            w_sp_is_empty;
    logic [SP_W-1:0] w_push_idx;
    logic [SP_W-1:0] w_pop_idx;
    logic            w_taken;
    logic [7:0]      w_target;
    logic            w_push;
    logic            w_pop;
    logic            w_err_set;
    logic [7:0]      w_next_ma;
    logic [SP_W:0]   w_next_sp;

    assign w_inc         = r_ma + 8'd1;
    assign w_sp_is_full  = (r_sp == c_SP_FULL);
    assign w_sp_is_empty = (r_sp == '0);

    // When not full the low bits of sp are the free slot. For a pop the
    // low bits minus one give the top entry; this also holds when sp is
    // exactly STACK_DEPTH because the low bits are then zero and wrap.
    assign w_push_idx = r_sp[SP_W-1:0];
    assign w_pop_idx  = r_sp[SP_W-1:0] - c_IDX_ONE;

    always_comb begin
        w_taken   = 1'b0;
        w_target  = micro_ad;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_set = 1'b0;

        case (bop)
            c_BOP_NEVER,
            c_BOP_NEVER2:  w_taken = 1'b0;
            c_BOP_ZERO:    w_taken = zero;
            c_BOP_CARRY:   w_taken = carry;
            c_BOP_SIGN:    w_taken = sign;
            c_BOP_GO_HIGH: w_taken = go_bar;
            c_BOP_NZERO:   w_taken = ~zero;
            c_BOP_NCARRY:  w_taken = ~carry;
            c_BOP_CALL: begin
                // A call on a full stack degrades to count/hold.
                if (w_sp_is_full) begin
                    w_err_set = 1'b1;
                end else begin
                    w_push  = 1'b1;
                    w_taken = 1'b1;
                end
            end
            c_BOP_RETURN: begin
                // A return on an empty stack degrades to count/hold.
                if (w_sp_is_empty) begin
                    w_err_set = 1'b1;
                end else begin
                    w_pop    = 1'b1;
                    w_taken  = 1'b1;
                    w_target = r_stack[w_pop_idx];
                end
            end
            c_BOP_ALWAYS:  w_taken = 1'b1;
            c_BOP_FETCH: begin
                w_taken  = 1'b1;
                w_target = {opcode, micro_ad[3:0]};
            end
            default:       w_taken = 1'b0;   // reserved 1010..1101
        endcase

        if (w_taken) begin
            w_next_ma = w_target;
        end else if (count) begin
            w_next_ma = w_inc;
        end else begin
            w_next_ma = r_ma;
        end

        if (w_push) begin
            w_next_sp = r_sp + c_SP_ONE;
        end else if (w_pop) begin
            w_next_sp = r_sp - c_SP_ONE;
        end else begin
            w_next_sp = r_sp;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ma    <= 8'h00;
            r_sp    <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ma    <= w_next_ma;
            r_sp    <= w_next_sp;
            r_empty <= (w_next_sp == '0);
            r_full  <= (w_next_sp == c_SP_FULL);
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Stack storage carries no reset; entries above sp are never read.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_stack[w_push_idx] <= w_inc;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign microaddress = r_ma;
    assign op_fetch     = (bop == c_BOP_FETCH);
    assign stack_empty  = r_empty;
    assign stack_full   = r_full;
    assign stack_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_micro_sequencer
//  Purpose  : Self-checking bench for micro_sequencer. A driver applies one
//             microword per cycle, steps a queue-based reference model and
//             pushes the expected response; a monitor pops and compares it
//             against the DUT every clock.
//  Revision : 1.0  initial release
// ============================================================================
module tb_micro_sequencer;

    localparam int c_DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] micro_ad;
    logic       count;
    logic [3:0] bop;
    logic [3:0] opcode;
    logic       go_bar;
    logic       zero;
    logic       carry;
    logic       sign;
    logic [7:0] microaddress;
    logic       op_fetch;
    logic       stack_empty;
    logic       stack_full;
    logic       stack_err;

    micro_sequencer #(.STACK_DEPTH(c_DEPTH), .SP_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .micro_ad     (micro_ad),
        .count        (count),
        .bop          (bop),
        .opcode       (opcode),
        .go_bar       (go_bar),
        .zero         (zero),
        .carry        (carry),
        .sign         (sign),
        .microaddress (microaddress),
        .op_fetch     (op_fetch),
        .stack_empty  (stack_empty),
        .stack_full   (stack_full),
        .stack_err    (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       of;
        bit [7:0] ma;
        bit       e;
        bit       f;
        bit       er;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: address, return stack as a queue, sticky error.
    bit [7:0] m_ma  = 8'h00;
    bit [7:0] m_stk[$];
    bit       m_err = 1'b0;

    function automatic void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void model_step(bit r, bit [3:0] b, bit [7:0] a, bit cnt,
                                       bit [3:0] op, bit gb, bit z, bit c, bit s);
        bit       tk;
        bit [7:0] tg;
        if (r) begin
            m_ma = 8'h00;
            m_stk.delete();
            m_err = 1'b0;
            return;
        end
        tk = 1'b0;
        tg = a;
        case (b)
            4'd1:  tk = z;
            4'd2:  tk = c;
            4'd3:  tk = s;
            4'd4:  tk = gb;
            4'd5:  tk = !z;
            4'd7:  tk = !c;
            4'd8: begin
                if (m_stk.size() < c_DEPTH) begin
                    m_stk.push_back(m_ma + 8'd1);
                    tk = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            4'd9: begin
                if (m_stk.size() > 0) begin
                    tg = m_stk.pop_back();
                    tk = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            4'd14: tk = 1'b1;
            4'd15: begin
                tk = 1'b1;
                tg = {op, a[3:0]};
            end
            default: tk = 1'b0;
        endcase
        if (tk)       m_ma = tg;
        else if (cnt) m_ma = m_ma + 8'd1;
    endfunction

    // One microinstruction cycle: drive on the falling edge, record expectation.
    task automatic step(input bit r, input bit [3:0] b, input bit [7:0] a, input bit cnt,
                        input bit [3:0] op = 4'h0, input bit gb = 1'b0,
                        input bit z = 1'b0, input bit c = 1'b1, input bit s = 1'b0);
        exp_t e;
        @(negedge clk);
        rst = r; bop = b; micro_ad = a; count = cnt; opcode = op;
        go_bar = gb; zero = z; carry = c; sign = s;
        e.of = (b == 4'hF);
        model_step(r, b, a, cnt, op, gb, z, c, s);
        e.ma = m_ma;
        e.e  = (m_stk.size() == 0);
        e.f  = (m_stk.size() == c_DEPTH);
        e.er = m_err;
        exp_q.push_back(e);
    endtask

    // Monitor: op_fetch is checked for the cycle ending at this edge, the
    // registered outputs just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("op_fetch", int'(op_fetch), int'(e.of));
                #1;
                check("microaddress", int'(microaddress), int'(e.ma));
                check("stack_empty", int'(stack_empty), int'(e.e));
                check("stack_full", int'(stack_full), int'(e.f));
                check("stack_err", int'(stack_err), int'(e.er));
            end
        end
    end

    initial begin
        rst = 1'b1; bop = 4'h0; micro_ad = 8'h00; count = 1'b0; opcode = 4'h0;
        go_bar = 1'b0; zero = 1'b0; carry = 1'b1; sign = 1'b0;

        // Reset and store sequence
        step(1, 4'h0, 8'h00, 0);
        step(0, 4'hE, 8'h0C, 0);
        step(0, 4'h6, 8'h00, 1);
        repeat (3) step(0, 4'h4, 8'h0D, 0, 4'h0, 1'b1);
        step(0, 4'h4, 8'h0D, 1, 4'h0, 1'b0);
        step(0, 4'hF, 8'hF1, 0, 4'h3);

        // Wrap and hold
        step(0, 4'hE, 8'hFF, 0);
        step(0, 4'h0, 8'h00, 1);
        step(0, 4'hE, 8'h40, 0);
        repeat (2) step(0, 4'h0, 8'h00, 0);

        // Conditionals
        step(0, 4'hE, 8'h10, 0);
        step(0, 4'h1, 8'h80, 0, 4'h0, 1'b0, 1'b1);
        step(0, 4'hE, 8'h10, 0);
        step(0, 4'h1, 8'h80, 1, 4'h0, 1'b0, 1'b0);
        step(0, 4'h7, 8'h33, 0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Call / return
        step(0, 4'hE, 8'h20, 0);
        step(0, 4'h8, 8'h50, 0);
        step(0, 4'h9, 8'h00, 0);

        // Overflow: four nested calls to 60, then a fifth with count=1
        repeat (4) step(0, 4'h8, 8'h60, 0);
        step(0, 4'h8, 8'h90, 1);

        // Underflow after reset
        step(1, 4'h0, 8'h00, 0);
        step(0, 4'hE, 8'h05, 0);
        step(0, 4'h9, 8'h00, 1);

        // Reset mid-operation with sp=2 and stack_err set
        step(0, 4'h8, 8'h30, 0);
        step(0, 4'h8, 8'h38, 0);
        step(1, 4'h8, 8'h44, 1);
        step(0, 4'h9, 8'h00, 1);

        // Randomised traffic, biased toward stack activity
        for (int i = 0; i < 600; i++) begin
            bit [3:0] b;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 2)      b = 4'h8;
            else if (sel < 4) b = 4'h9;
            else              b = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 59) == 0), b, 8'($urandom), 1'($urandom),
                 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
